// File: rtl/store_narrow_buffer.sv
// store_narrow_buffer
// Narrows 32-bit store operands to byte/half/word and replicates them across
// byte lanes with little-endian byte enables. Buffers the stores in a FIFO and
// drains them to data memory over a req/ack handshake.
// Optional feature macro: STORE_ALIGN_CHECK_EN. When it is defined, misaligned
// requests are consumed, dropped and reported on st_adex. When it is undefined,
// st_adex is tied low and every accepted request is enqueued.
module store_narrow_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    input  logic [1:0]    st_size,
    output logic          st_adex,
    output logic          mem_req,
    input  logic          mem_ack,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int            PW         = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_mem_req;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [31:0]   r_addr_q  [DEPTH];
    logic [31:0]   r_wdata_q [DEPTH];
    logic [3:0]    r_be_q    [DEPTH];

    logic [1:0]    w_a;
    logic [31:0]   w_wdata;
    logic [3:0]    w_be;
    logic          w_misaligned;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_next;

    assign w_a = st_addr[1:0];

    // Lane replication and byte-enable generation for the incoming store.
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        w_wdata = st_data;
        w_be    = 4'b1111;
        case (st_size)
            2'b00: begin
                w_wdata = {4{st_data[7:0]}};
                w_be    = 4'b0001 << w_a;
            end
            2'b01: begin
                w_wdata = {2{st_data[15:0]}};
                w_be    = w_a[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                // Word, and the reserved size handled as a word when it is not dropped.
                w_wdata = st_data;
                w_be    = 4'b1111;
            end
        endcase
    end

`ifdef STORE_ALIGN_CHECK_EN
    assign w_misaligned = (st_size == 2'b11)
                        || (st_size == 2'b10 && w_a != 2'b00)
                        || (st_size == 2'b01 && w_a[0]);
`else
    assign w_misaligned = 1'b0;
`endif

    assign st_ready = !rst && (r_count < FULL_COUNT);
    assign w_accept = st_valid && st_ready;
    assign w_push   = w_accept && !w_misaligned;
    // An ack only counts while the head is actually being offered.
    assign w_pop    = r_mem_req && mem_ack;

    // Occupancy after this edge; simultaneous push and pop cancel out.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Entry storage, written at the tail on every enqueue.
    // NOTE: storage has no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[r_wr_ptr]  <= {st_addr[31:2], 2'b00};
            r_wdata_q[r_wr_ptr] <= w_wdata;
            r_be_q[r_wr_ptr]    <= w_be;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_next;
        end
    end

    // Drain FSM: offer the head whenever the buffer will hold something after this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_count_next != '0) begin
                        r_state   <= S_REQ;
                        r_mem_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (w_pop && w_count_next == '0) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef STORE_ALIGN_CHECK_EN
    logic r_adex;

    // One-cycle pulse after each accepted misaligned request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_adex <= 1'b0;
        end else begin
            r_adex <= w_accept && w_misaligned;
        end
    end

    assign st_adex = r_adex;
`else
    assign st_adex = 1'b0;
`endif

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_addr_q[r_rd_ptr];
    assign mem_wdata = r_wdata_q[r_rd_ptr];
    assign mem_be    = r_be_q[r_rd_ptr];
    assign count     = r_count;
    assign empty     = (r_count == '0);

endmodule

// File: doc/store_narrow_buffer.md
# store_narrow_buffer

Store-side counterpart of the load/immediate extension path. It takes 32-bit store operands from the MEM stage and narrows each one to byte, half or word width. Each narrowed value is replicated onto its byte lanes and given little-endian byte enables. Stores are buffered in a small FIFO and drained to data memory over a req/ack handshake, so memory latency does not stall the pipeline until the buffer fills.

## Interface
Parameters:
- DEPTH, 4, number of buffer entries; power of 2, ≥2
- CW, 3, width of count; must equal log2(DEPTH)+1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store request present
- st_ready  out  1  buffer can accept a request
- st_addr  in  32  byte address of the store
- st_data  in  32  register operand; only the low bits are used for byte and half stores
- st_size  in  2  store width: 00 = byte, 01 = half, 10 = word, 11 = reserved
- st_adex  out  1  one-cycle address-error pulse (see Configuration)
- mem_req  out  1  head entry is valid and offered to memory
- mem_ack  in  1  memory accepted the head entry
- mem_addr  out  32  word address: st_addr[31:2], 2'b00
- mem_wdata  out  32  lane-replicated write data
- mem_be  out  4  byte enables; bit i enables bits [8i+7:8i]
- count  out  CW  number of occupied entries
- empty  out  1  count == 0

## Operation
Narrowing, with a = st_addr[1:0]:
- byte: wdata = {4{st_data[7:0]}}; be = 4'b0001 << a
- half: wdata = {2{st_data[15:0]}}; be = a[1] ? 4'b1100 : 4'b0011
- word: wdata = st_data; be = 4'b1111

Misalignment:
- A half store with a[0]=1 is misaligned.
- A word store with a≠0 is misaligned.
- Size 11 is always treated as misaligned.

Accept and enqueue:
- A request is accepted on a rising edge when st_valid && st_ready.
- An accepted, aligned request pushes {mem_addr, wdata, be} at the tail.
- An accepted, misaligned request is consumed but never enqueued.

Drain FSM, two states:
- IDLE: mem_req=0. Go to REQ when count≠0.
- REQ: mem_req=1 and the head fields are stable. On mem_ack the head is popped. Stay in REQ if count after pop ≠0, otherwise go to IDLE.

Flow control:
- st_ready = !rst && count<DEPTH.
- Push and pop on the same edge leave count unchanged.
- Full: st_ready=0 with no bypass. An edge that pops from full raises st_ready on the following cycle.
- Pointers wrap modulo DEPTH.
- Entries leave in strict FIFO order.

## Timing
Reset (rst high at an edge):
- Pointers, count, FSM and st_adex are cleared: count=0, empty=1, mem_req=0, st_adex=0, FSM=IDLE.
- All buffered stores are discarded, including a head currently being offered with mem_req=1. A mem_ack arriving in the same cycle is ignored.
- st_ready is 0 while rst is high.

Latency:
- A push at edge N raises mem_req after edge N when the FIFO was empty. Minimum latency is 1 cycle from acceptance to mem_req.
- A write is complete on the edge where mem_req && mem_ack are both high.
- Back-to-back acks drain one entry per cycle.

Handshake:
- mem_ack is ignored when mem_req=0.
- While mem_req=1 and mem_ack=0, mem_addr, mem_wdata and mem_be are held unchanged.

st_adex:
- Registered; high for exactly the one cycle after the edge that accepted a misaligned request.
- Consecutive misaligned requests give consecutive pulses.

## Configuration
Macro STORE_ALIGN_CHECK_EN.

Defined:
- Misalignment is detected as in Operation, dropped and reported on st_adex.

Undefined:
- st_adex is tied to 0 and no request is dropped.
- Half stores use a[1] only to select lanes.
- Word stores always use be=4'b1111 and ignore a.
- Size 11 is enqueued as a word store.

## Test plan
- Byte, half and word stores: size=00 addr=0x1003 data=0xAABBCCDD -> mem_addr=0x1000, wdata=0xDDDDDDDD, be=1000. Size=01 addr=0x2002 -> wdata=0xCCDDCCDD, be=1100. Size=10 addr=0x3000 -> wdata=0xAABBCCDD, be=1111.
- Fill with mem_ack=0: 4 word pushes -> count=4, st_ready=0, 5th request held. Single ack -> count=3 and st_ready=1 next cycle. Continuous acks drain entries in push order.
- Simultaneous push and pop at count=2 -> count stays 2, next head is the second-oldest entry.
- Misaligned word at addr=0x0002 (macro defined) -> accepted, st_adex=1 for one cycle, count unchanged, no mem_req. Macro undefined -> enqueued with be=1111, mem_addr=0x0000.
- Reset with count=3 and mem_req=1, mem_ack=1 asserted in the same cycle -> next cycle count=0, mem_req=0, empty=1, no entry delivered, st_ready=1 once rst drops.
